// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle driven by vga_timing_gen
interface vga_timing_gen_if;
  logic       pix_tick;
  logic [9:0] h_line;
  logic [9:0] v_line;
  logic       valid_out;
  logic       frame_start;
  logic       hsync_n;
  logic       vsync_n;
  logic       blank_n;
  modport master (output pix_tick, h_line, v_line, valid_out, frame_start, hsync_n, vsync_n, blank_n);
  modport slave (input pix_tick, h_line, v_line, valid_out, frame_start, hsync_n, vsync_n, blank_n);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, active-video decode and pipelined sync/blank
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..4");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..3");
  end

  logic [1:0]  r_div;
  logic        r_pix_tick;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic        r_valid;
  logic        r_frame_start;
  logic [2:0]  r_pipe [PIPE_DLY+1];
  logic        w_h_wrap;
  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic [10:0] w_h11;
  logic [10:0] w_v11;
  logic        w_valid_nxt;
  logic        w_hs_nxt;
  logic        w_vs_nxt;

  // pixel-clock enable: registered pulse on the divider's last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= 2'd0;
      r_pix_tick <= 1'b0;
    end else begin
      r_div      <= (r_div == DIV_LAST) ? 2'd0 : r_div + 2'd1;
      r_pix_tick <= (r_div == DIV_LAST);
    end
  end

  // next raster position and the decodes that describe it
  always_comb begin
    w_h_wrap    = (r_h == H_LAST);
    w_h_nxt     = w_h_wrap ? 10'd0 : r_h + 10'd1;
    w_v_nxt     = !w_h_wrap ? r_v : (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
    w_h11       = {1'b0, w_h_nxt};
    w_v11       = {1'b0, w_v_nxt};
    w_valid_nxt = (w_h11 < H_ACT) && (w_v11 < V_ACT);
    w_hs_nxt    = !((w_h11 >= H_SS) && (w_h11 < H_SE));
    w_vs_nxt    = !((w_v11 >= V_SS) && (w_v11 < V_SE));
  end

  // raster counters and qualifiers, updated together on each pixel tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h           <= H_LAST;
      r_v           <= V_LAST;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (r_pix_tick) begin
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_valid       <= w_valid_nxt;
      r_frame_start <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
    end
  end

  // sync/blank delay line; stage 0 holds the raw {hs, vs, blank} of the current count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= PIPE_DLY; i++) r_pipe[i] <= 3'b110;
    end else if (r_pix_tick) begin
      r_pipe[0] <= {w_hs_nxt, w_vs_nxt, w_valid_nxt};
      for (int i = 1; i <= PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign vif.pix_tick    = r_pix_tick;
  assign vif.h_line      = r_h;
  assign vif.v_line      = r_v;
  assign vif.valid_out   = r_valid;
  assign vif.frame_start = r_frame_start;
  assign vif.hsync_n     = r_pipe[PIPE_DLY][2];
  assign vif.vsync_n     = r_pipe[PIPE_DLY][1];
  assign vif.blank_n     = r_pipe[PIPE_DLY][0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen across four configurations
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();
  vga_timing_gen_if if3 ();

  vga_timing_gen u0 (.clk(clk), .rst_n(rst_n), .vif(if0));
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(1))
    u1 (.clk(clk), .rst_n(rst_n), .vif(if1));
  vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0)) u2 (.clk(clk), .rst_n(rst_n), .vif(if2));
  vga_timing_gen #(.CLK_DIV(4)) u3 (.clk(clk), .rst_n(rst_n), .vif(if3));

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [25:0] exp_seq [5];
    logic [25:0] got;
    exp_seq[0] = {1'b0, 10'd799, 10'd524, 5'b00110};
    exp_seq[1] = {1'b1, 10'd799, 10'd524, 5'b00110};
    exp_seq[2] = {1'b0, 10'd0, 10'd0, 5'b11110};
    exp_seq[3] = {1'b1, 10'd0, 10'd0, 5'b11110};
    exp_seq[4] = {1'b0, 10'd1, 10'd0, 5'b10111};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    got = {if0.pix_tick, if0.h_line, if0.v_line, if0.valid_out, if0.frame_start, if0.hsync_n, if0.vsync_n, if0.blank_n};
    n_cmp++;
    if (got !== exp_seq[0]) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", got, exp_seq[0]); end
    n_cmp++;
    if ({if1.h_line, if1.v_line} !== {10'd15, 10'd10}) begin
      n_bad++; $display("FAIL reset_small: got h=%0d v=%0d expected h=15 v=10", if1.h_line, if1.v_line);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      got = {if0.pix_tick, if0.h_line, if0.v_line, if0.valid_out, if0.frame_start, if0.hsync_n, if0.vsync_n, if0.blank_n};
      n_cmp++;
      if (got !== exp_seq[k]) begin n_bad++; $display("FAIL reset_release_%0d: got %h expected %h", k, got, exp_seq[k]); end
      if (k == 0) begin
        n_cmp++;
        if (if2.pix_tick !== 1'b1) begin n_bad++; $display("FAIL div1_first_tick: got %b expected 1", if2.pix_tick); end
      end
      if (k == 1) begin
        n_cmp++;
        if ({if2.h_line, if2.v_line, if2.frame_start} !== {10'd0, 10'd0, 1'b1}) begin
          n_bad++; $display("FAIL div1_first_pos: got h=%0d v=%0d fs=%b expected 0 0 1", if2.h_line, if2.v_line, if2.frame_start);
        end
      end
    end
  endtask

  task automatic test_full_line();
    logic [9:0] ph;
    logic [9:0] eh;
    logic ehs;
    int lows;
    int t0;
    int t1;
    lows = 0; t0 = -1; t1 = -1; ph = 10'd1;
    for (int c = 0; c < 4000 && t1 < 0; c++) begin
      @(negedge clk);
      if (if0.h_line !== ph) begin
        eh = (ph == 10'd799) ? 10'd0 : ph + 10'd1;
        ehs = !(ph >= 10'd656 && ph < 10'd752);
        n_cmp++;
        if (if0.h_line !== eh) begin n_bad++; $display("FAIL line_h: got %0d expected %0d", if0.h_line, eh); end
        n_cmp++;
        if (if0.hsync_n !== ehs) begin n_bad++; $display("FAIL line_hsync at h=%0d: got %b expected %b", eh, if0.hsync_n, ehs); end
        n_cmp++;
        if (if0.valid_out !== (eh < 10'd640)) begin n_bad++; $display("FAIL line_valid at h=%0d: got %b expected %b", eh, if0.valid_out, eh < 10'd640); end
        if (t0 >= 0 && !if0.hsync_n) lows++;
        if (eh == 10'd0) begin
          if (t0 < 0) t0 = cyc;
          else t1 = cyc;
        end
        ph = eh;
      end
    end
    n_cmp++;
    if (t1 < 0) begin n_bad++; $display("FAIL line_timeout: got no second line start expected one within 4000 clks"); end
    else if (t1 - t0 != 1600) begin n_bad++; $display("FAIL line_period: got %0d clks expected 1600", t1 - t0); end
    n_cmp++;
    if (lows != 96) begin n_bad++; $display("FAIL line_hsync_width: got %0d ticks expected 96", lows); end
  endtask

  task automatic test_frame();
    logic [9:0] ph;
    logic [9:0] pv;
    logic [9:0] eh;
    logic [9:0] ev;
    logic [1:0] edec;
    logic [2:0] esync;
    int ticks;
    int fs_cnt;
    int vs_low;
    ticks = 0; fs_cnt = 0; vs_low = 0; ph = 10'd15; pv = 10'd10;
    pulse_reset();
    for (int c = 0; c < 1000 && ticks < 352; c++) begin
      @(negedge clk);
      if (if1.h_line !== ph) begin
        ticks++;
        eh = (ph == 10'd15) ? 10'd0 : ph + 10'd1;
        ev = (ph != 10'd15) ? pv : (pv == 10'd10) ? 10'd0 : pv + 10'd1;
        edec = {eh < 10'd8 && ev < 10'd6, eh == 10'd0 && ev == 10'd0};
        esync = {!(ph >= 10'd10 && ph < 10'd13), !(pv >= 10'd7 && pv < 10'd9), ph < 10'd8 && pv < 10'd6};
        n_cmp++;
        if ({if1.h_line, if1.v_line} !== {eh, ev}) begin
          n_bad++; $display("FAIL frame_count: got (%0d,%0d) expected (%0d,%0d)", if1.h_line, if1.v_line, eh, ev);
        end
        n_cmp++;
        if ({if1.valid_out, if1.frame_start} !== edec) begin
          n_bad++; $display("FAIL frame_decode at (%0d,%0d): got %b%b expected %b", eh, ev, if1.valid_out, if1.frame_start, edec);
        end
        n_cmp++;
        if ({if1.hsync_n, if1.vsync_n, if1.blank_n} !== esync) begin
          n_bad++; $display("FAIL frame_sync at (%0d,%0d): got %b%b%b expected %b", eh, ev, if1.hsync_n, if1.vsync_n, if1.blank_n, esync);
        end
        fs_cnt += int'(if1.frame_start);
        vs_low += int'(!if1.vsync_n);
        ph = eh; pv = ev;
      end
    end
    n_cmp++;
    if (ticks != 352) begin n_bad++; $display("FAIL frame_timeout: got %0d ticks expected 352", ticks); end
    n_cmp++;
    if (fs_cnt != 2) begin n_bad++; $display("FAIL frame_start_count: got %0d expected 2", fs_cnt); end
    n_cmp++;
    if (vs_low != 64) begin n_bad++; $display("FAIL frame_vsync_width: got %0d ticks expected 64", vs_low); end
  endtask

  task automatic test_overlay();
    logic [9:0] th [3];
    logic [9:0] tv [3];
    logic evl [3];
    logic found;
    logic moved;
    th[0] = 10'd5; tv[0] = 10'd3; evl[0] = 1'b1;
    th[1] = 10'd7; tv[1] = 10'd5; evl[1] = 1'b1;
    th[2] = 10'd8; tv[2] = 10'd5; evl[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      found = 1'b0;
      for (int c = 0; c < 800 && !found; c++) begin
        @(negedge clk);
        if (if1.h_line == th[i] && if1.v_line == tv[i]) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin n_bad++; $display("FAIL overlay_timeout_%0d: got no visit expected (%0d,%0d)", i, th[i], tv[i]); end
      else if (if1.valid_out !== evl[i]) begin
        n_bad++; $display("FAIL overlay_valid (%0d,%0d): got %b expected %b", th[i], tv[i], if1.valid_out, evl[i]);
      end
      moved = 1'b0;
      for (int c = 0; c < 8 && !moved; c++) begin
        @(negedge clk);
        if (if1.h_line != th[i]) moved = 1'b1;
      end
      n_cmp++;
      if (if1.blank_n !== evl[i]) begin
        n_bad++; $display("FAIL overlay_blank (%0d,%0d): got %b expected %b", th[i], tv[i], if1.blank_n, evl[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [25:0] got;
    logic found;
    pulse_reset();
    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (if0.h_line == 10'd400 && if0.v_line == 10'd1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL midrst_timeout: got no visit expected (400,1)"); end
    #1 rst_n = 1'b0;
    #1 got = {if0.pix_tick, if0.h_line, if0.v_line, if0.valid_out, if0.frame_start, if0.hsync_n, if0.vsync_n, if0.blank_n};
    n_cmp++;
    if (got !== {1'b0, 10'd799, 10'd524, 5'b00110}) begin
      n_bad++; $display("FAIL midrst_async: got %h expected %h", got, {1'b0, 10'd799, 10'd524, 5'b00110});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    got = {if0.pix_tick, if0.h_line, if0.v_line, if0.valid_out, if0.frame_start, if0.hsync_n, if0.vsync_n, if0.blank_n};
    n_cmp++;
    if (got !== {1'b0, 10'd0, 10'd0, 5'b11110}) begin
      n_bad++; $display("FAIL midrst_restart: got %h expected %h", got, {1'b0, 10'd0, 10'd0, 5'b11110});
    end
  endtask

  task automatic test_cfg_div1();
    logic [9:0] ph;
    logic [9:0] eh;
    pulse_reset();
    @(negedge clk);
    n_cmp++;
    if ({if2.pix_tick, if2.h_line} !== {1'b1, 10'd799}) begin
      n_bad++; $display("FAIL div1_start: got tick=%b h=%0d expected 1 799", if2.pix_tick, if2.h_line);
    end
    ph = 10'd799;
    for (int c = 0; c < 1800; c++) begin
      @(negedge clk);
      eh = (ph == 10'd799) ? 10'd0 : ph + 10'd1;
      n_cmp++;
      if ({if2.pix_tick, if2.h_line} !== {1'b1, eh}) begin
        n_bad++; $display("FAIL div1_tick: got tick=%b h=%0d expected 1 %0d", if2.pix_tick, if2.h_line, eh);
      end
      n_cmp++;
      if ({if2.hsync_n, if2.blank_n} !== {!(eh >= 10'd656 && eh < 10'd752), eh < 10'd640}) begin
        n_bad++; $display("FAIL div1_sync at h=%0d: got hs=%b bl=%b expected %b %b", eh, if2.hsync_n, if2.blank_n,
                          !(eh >= 10'd656 && eh < 10'd752), eh < 10'd640);
      end
      ph = eh;
    end
  endtask

  task automatic test_cfg_div4();
    int t0;
    int t1;
    int highs;
    logic found;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if3.pix_tick !== (k == 3)) begin n_bad++; $display("FAIL div4_tick_%0d: got %b expected %b", k, if3.pix_tick, k == 3); end
    end
    n_cmp++;
    if ({if3.h_line, if3.v_line, if3.frame_start} !== {10'd0, 10'd0, 1'b1}) begin
      n_bad++; $display("FAIL div4_first: got h=%0d v=%0d fs=%b expected 0 0 1", if3.h_line, if3.v_line, if3.frame_start);
    end
    t0 = cyc; t1 = 0; highs = 0; found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (if3.pix_tick) highs++;
      if (if3.h_line == 10'd0 && if3.v_line == 10'd1) begin found = 1'b1; t1 = cyc; end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL div4_timeout: got no line wrap expected one within 4000 clks"); end
    else if (t1 - t0 != 3200) begin n_bad++; $display("FAIL div4_period: got %0d clks expected 3200", t1 - t0); end
    n_cmp++;
    if (highs != 800) begin n_bad++; $display("FAIL div4_tick_count: got %0d expected 800", highs); end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_frame();
    test_overlay();
    test_mid_reset();
    test_cfg_div1();
    test_cfg_div4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
